// File: rtl/types_pkg.sv
// Shared memory-path types: data bus width, access-size encoding and the arbiter states.
package types_pkg;

    localparam int DATA_BUS = 32;

    typedef logic [1:0] byte_format;

    localparam byte_format BYTE_BYTE = 2'b00;
    localparam byte_format BYTE_HALF = 2'b01;
    localparam byte_format BYTE_WORD = 2'b10;

    typedef enum logic {
        ARB_CPU,
        ARB_HOST
    } arb_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that holds once it reaches MAX.
module sat_counter #(
    parameter int MAX = 4,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_q, cnt_d;

    // Clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && (cnt_q != MAX_V))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU has default priority, the host is forced through after
// MAX_WAIT denied cycles and may then hold the port for a locked burst of up to MAX_BURST beats.
module dmem_arbiter
    import types_pkg::*;
#(
    parameter int MAX_WAIT  = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [DATA_BUS-1:0] cpu_addr,
    input  logic [DATA_BUS-1:0] cpu_wdata,
    input  byte_format          cpu_bsel,
    input  logic                cpu_sext,
    output logic [DATA_BUS-1:0] cpu_rdata,
    output logic                cpu_stall,
    input  logic                host_req,
    input  logic                host_lock,
    input  logic                host_we,
    input  logic [DATA_BUS-1:0] host_addr,
    input  logic [DATA_BUS-1:0] host_wdata,
    output logic                host_gnt,
    output logic [DATA_BUS-1:0] host_rdata,
    output logic                host_rvalid,
    output logic [DATA_BUS-1:0] mem_a,
    output logic [DATA_BUS-1:0] mem_wd,
    output logic                mem_we,
    output byte_format          mem_bsel,
    output logic                mem_sext,
    input  logic [DATA_BUS-1:0] mem_rd
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [WW-1:0] WAIT_MAX   = WW'(MAX_WAIT);
    // burst_cnt counts beats already granted, so the beat seen at MAX_BURST-1 is the last one.
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
    localparam bit            CAN_LOCK   = (MAX_BURST > 1);

    arb_state_t          state_q, state_d;
    logic [WW-1:0]       wait_cnt;
    logic [BW-1:0]       burst_cnt;
    logic                wait_clr, wait_inc;
    logic                burst_clr, burst_inc;
    logic [DATA_BUS-1:0] host_rdata_q, host_rdata_d;
    logic                host_rvalid_q, host_rvalid_d;

    sat_counter #(.MAX(MAX_WAIT), .W(WW)) u_wait_cnt (
        .clk (clk),
        .rst (rst),
        .clr (wait_clr),
        .inc (wait_inc),
        .cnt (wait_cnt)
    );

    sat_counter #(.MAX(MAX_BURST), .W(BW)) u_burst_cnt (
        .clk (clk),
        .rst (rst),
        .clr (burst_clr),
        .inc (burst_inc),
        .cnt (burst_cnt)
    );

    always_comb begin
        state_d   = state_q;
        host_gnt  = 1'b0;
        wait_clr  = 1'b1;
        wait_inc  = 1'b0;
        burst_clr = 1'b1;
        burst_inc = 1'b0;
        case (state_q)
            ARB_CPU: begin
                host_gnt = host_req & (~cpu_req | (wait_cnt == WAIT_MAX));
                wait_inc = host_req & ~host_gnt;
                wait_clr = ~wait_inc;
                if (host_gnt && host_lock && CAN_LOCK) begin
                    state_d   = ARB_HOST;
                    burst_clr = 1'b0;
                    burst_inc = 1'b1;
                end
            end
            ARB_HOST: begin
                host_gnt = host_req;
                if (!host_req || !host_lock || (burst_cnt == BURST_LAST)) begin
                    state_d = ARB_CPU;
                end else begin
                    burst_clr = 1'b0;
                    burst_inc = 1'b1;
                end
            end
            default: state_d = ARB_CPU;
        endcase
    end

    // With no owner the CPU fields still drive the port; only the write enable is gated.
    always_comb begin
        mem_a     = host_gnt ? host_addr  : cpu_addr;
        mem_wd    = host_gnt ? host_wdata : cpu_wdata;
        mem_we    = host_gnt ? host_we    : (cpu_req & cpu_we);
        mem_bsel  = host_gnt ? BYTE_WORD  : cpu_bsel;
        mem_sext  = host_gnt ? 1'b0       : cpu_sext;
        cpu_rdata = mem_rd;
        cpu_stall = cpu_req & host_gnt;
    end

    always_comb begin
        host_rdata_d  = host_rdata_q;
        host_rvalid_d = 1'b0;
        if (host_gnt && !host_we) begin
            host_rdata_d  = mem_rd;
            host_rvalid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ARB_CPU;
            host_rdata_q  <= '0;
            host_rvalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            host_rdata_q  <= host_rdata_d;
            host_rvalid_q <= host_rvalid_d;
        end
    end

    assign host_rdata  = host_rdata_q;
    assign host_rvalid = host_rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios queue expected grant cycles and
// host read data; a negedge monitor pops and compares whenever the DUT presents them.
module tb_dmem_arbiter;
    import types_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_sext;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    byte_format  cpu_bsel;
    logic        cpu_stall;
    logic        host_req, host_lock, host_we;
    logic [31:0] host_addr, host_wdata, host_rdata;
    logic        host_gnt, host_rvalid;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic        mem_we, mem_sext;
    byte_format  mem_bsel;

    always #5 clk = ~clk;

    dmem_arbiter #(.MAX_WAIT(4), .MAX_BURST(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_bsel    (cpu_bsel),
        .cpu_sext    (cpu_sext),
        .cpu_rdata   (cpu_rdata),
        .cpu_stall   (cpu_stall),
        .host_req    (host_req),
        .host_lock   (host_lock),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (host_gnt),
        .host_rdata  (host_rdata),
        .host_rvalid (host_rvalid),
        .mem_a       (mem_a),
        .mem_wd      (mem_wd),
        .mem_we      (mem_we),
        .mem_bsel    (mem_bsel),
        .mem_sext    (mem_sext),
        .mem_rd      (mem_rd)
    );

    // Word-wide data memory with combinational read.
    logic [31:0] mem [0:255];
    assign mem_rd = mem[mem_a[9:2]];
    always @(posedge clk) if (mem_we) mem[mem_a[9:2]] <= mem_wd;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks = 0;
    int          errors = 0;
    int          exp_gnt[$];
    logic [31:0] exp_rd[$];
    logic        gexp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds host_req until n beats are granted; host_lock is high for the first nlock beats.
    task automatic host_run(input int n, input int nlock, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata);
        int done = 0;
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = addr;
        host_wdata = wdata;
        for (int t = 0; t < 40 && done < n; t++) begin
            host_lock = (done < nlock);
            #3;
            if (host_gnt) done++;
            tick();
        end
        if (done < n) begin
            checks++;
            errors++;
            $display("FAIL host_run_timeout actual=%0d required=%0d", done, n);
        end
        host_req  = 1'b0;
        host_lock = 1'b0;
    endtask

    always @(negedge clk) begin
        gexp = (exp_gnt.size() > 0) && (exp_gnt[0] == cyc);
        if (gexp || host_gnt) chk("host_gnt", 32'(host_gnt), 32'(gexp));
        if (gexp) void'(exp_gnt.pop_front());
        chk("cpu_stall", 32'(cpu_stall), 32'(gexp & cpu_req));
        if (host_gnt) begin
            chk("mem_bsel_host", 32'(mem_bsel), 32'(BYTE_WORD));
            chk("mem_sext_host", 32'(mem_sext), 32'd0);
        end
        if (host_rvalid) begin
            if (exp_rd.size() == 0) chk("host_rvalid_unexpected", 32'd1, 32'd0);
            else                    chk("host_rdata", host_rdata, exp_rd.pop_front());
        end
    end

    initial begin
        int c0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        rst = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_sext = 0; cpu_addr = '0; cpu_wdata = '0; cpu_bsel = BYTE_WORD;
        host_req = 0; host_lock = 0; host_we = 0; host_addr = '0; host_wdata = '0;

        repeat (2) tick();
        chk("reset_rvalid", 32'(host_rvalid), 32'd0);
        chk("reset_rdata", host_rdata, 32'd0);
        rst = 1'b0;
        tick();

        // CPU only: store then load back.
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h100; cpu_wdata = 32'hDEADBEEF;
        #3 chk("cpu_store_we", 32'(mem_we), 32'd1);
        tick();
        cpu_we = 0;
        #3 chk("cpu_load", cpu_rdata, 32'hDEADBEEF);
        tick();

        // Starvation: CPU loads 0x40 every cycle with non-word size; host forced on 5th cycle.
        cpu_addr = 32'h40; cpu_bsel = BYTE_BYTE; cpu_sext = 1;
        c0 = cyc;
        exp_gnt.push_back(c0 + 4);
        exp_rd.push_back(32'hDEADBEEF);
        host_run(1, 0, 1'b0, 32'h100, 32'h0);
        tick();

        // Idle CPU: host write granted at once, CPU reads it the next cycle.
        cpu_req = 0; cpu_bsel = BYTE_WORD; cpu_sext = 0;
        c0 = cyc;
        exp_gnt.push_back(c0);
        host_run(1, 0, 1'b1, 32'h40, 32'h12345678);
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
        #3 chk("cpu_load_after_host_wr", cpu_rdata, 32'h12345678);
        tick();

        // Locked burst of 12 beats: 8 grants, CPU cycle, wait again, then 4 more.
        c0 = cyc;
        for (int k = 4; k <= 11; k++) exp_gnt.push_back(c0 + k);
        for (int k = 16; k <= 19; k++) exp_gnt.push_back(c0 + k);
        repeat (12) exp_rd.push_back(32'hDEADBEEF);
        host_run(12, 12, 1'b0, 32'h100, 32'h0);
        tick();

        // Lock dropped on beat 3, then a fresh request must wait the full MAX_WAIT.
        c0 = cyc;
        for (int k = 4; k <= 6; k++) exp_gnt.push_back(c0 + k);
        repeat (3) exp_rd.push_back(32'h12345678);
        host_run(3, 2, 1'b0, 32'h40, 32'h0);
        c0 = cyc;
        exp_gnt.push_back(c0 + 4);
        exp_rd.push_back(32'h12345678);
        host_run(1, 0, 1'b0, 32'h40, 32'h0);
        tick();

        // Reset during beat 2 of a locked read burst.
        cpu_req = 0;
        c0 = cyc;
        exp_gnt.push_back(c0);
        exp_gnt.push_back(c0 + 1);
        exp_rd.push_back(32'hDEADBEEF);
        host_req = 1; host_lock = 1; host_we = 0; host_addr = 32'h100;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cpu_req = 1;
        #3;
        chk("post_rst_gnt", 32'(host_gnt), 32'd0);
        chk("post_rst_rvalid", 32'(host_rvalid), 32'd0);
        chk("post_rst_rdata", host_rdata, 32'd0);
        tick();
        host_req = 0; host_lock = 0;
        repeat (2) tick();

        chk("gnt_queue_empty", 32'(exp_gnt.size()), 32'd0);
        chk("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
